pipe_divider_param: RTL
=======================

PIPE_DIVIDER_PARAM -- requirements
Module: pipe_divider_param

Interface
REQ-001 SHALL: parameter N_W, default 28, dividend width and quotient width (minimum 2).
REQ-002 SHALL: parameter D_W, default 20, divisor width and remainder width (minimum 2).
REQ-003 SHALL: parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-004 SHALL: clock  input  1  rising-edge clock.
REQ-005 SHALL: reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL: flush  input  1  synchronous pipeline clear.
REQ-007 SHALL: in_valid  input  1  operation offered.
REQ-008 SHALL: in_ready  output  1  operation accepted this cycle when high together with in_valid.
REQ-009 SHALL: dividend  input  N_W  unsigned dividend.
REQ-010 SHALL: divisor  input  D_W  unsigned divisor.
REQ-011 SHALL: in_tag  input  TAG_W  sideband tag.
REQ-012 SHALL: out_valid  output  1  result present.
REQ-013 SHALL: out_ready  input  1  consumer accepts the result.
REQ-014 SHALL: quotient  output  N_W  unsigned quotient.
REQ-015 SHALL: remainder  output  D_W  remainder; present only when PIPE_DIV_REM_EN is defined.
REQ-016 SHALL: div_by_zero  output  1  result came from a zero divisor.
REQ-017 SHALL: out_tag  output  TAG_W  tag of the result.

Function
REQ-018 SHALL: registered stages S0..S(N_W); S0 captures accepted inputs; stage Sk holds k resolved quotient bits, partial remainder (D_W+1 bits), remaining dividend bits, divisor, tag, zero flag and valid bit.
REQ-019 SHALL: per stage, unsigned restoring step: trial = {partial remainder, next dividend MSB} - {0, divisor}; trial non-negative -> quotient bit 1 and partial remainder = trial, else quotient bit 0 and partial remainder unchanged except for the shift.
REQ-020 SHALL: outputs driven directly from S(N_W); latency from accept to out_valid is exactly N_W+1 rising edges with no stall.
REQ-021 SHALL: stall = out_valid && !out_ready; during stall every stage holds its contents.
REQ-022 SHALL: in_ready = !stall && !flush.
REQ-023 SHALL: without stall, one operation accepted per cycle (full throughput); results emerge in acceptance order with their tags.
REQ-024 SHALL: divisor == 0 -> quotient all ones, remainder = dividend[D_W-1:0] zero-extended or truncated, div_by_zero = 1; otherwise div_by_zero = 0.
REQ-025 SHALL: bubbles (valid 0) advance like data; quotient, remainder and out_tag are 0 whenever out_valid is 0.
REQ-026 SHALL: flush high at an edge -> all valid bits cleared, all stage data cleared; flush overrides stall and in_valid, and the input offered that cycle is not accepted.
REQ-027 SHALL: in_valid with in_ready low -> no capture; the source holds its inputs.

Reset
REQ-028 SHALL: reset_n low -> immediately all valid bits 0, out_valid 0, quotient 0, remainder 0, div_by_zero 0, out_tag 0, all stage data 0.
REQ-029 SHALL: reset asserted mid-operation discards all in-flight operations; no result from before reset appears after release.
REQ-030 SHALL: in_ready is 1 on the first cycle after reset release when flush and stall are low.

Configuration
REQ-031 SHALL: macro PIPE_DIV_REM_EN defined -> remainder port present and each stage carries the final partial remainder to the output.
REQ-032 SHALL: PIPE_DIV_REM_EN undefined -> remainder port absent; stages carry partial remainder only as needed for quotient bits; quotient, timing and handshake identical.

Verification (N_W=8, D_W=8, TAG_W=4, PIPE_DIV_REM_EN defined)
REQ-033 SHALL: accept 200/7, tag 3 -> 9 edges later out_valid=1, quotient=28, remainder=4, out_tag=3, div_by_zero=0.
REQ-034 SHALL: back-to-back 255/1, 255/255, 10/20 on consecutive cycles -> three consecutive results: q=255 r=0; q=1 r=0; q=0 r=10.
REQ-035 SHALL: 77/0 -> quotient=255, remainder=77, div_by_zero=1.
REQ-036 SHALL: out_ready held low for 5 cycles while the result is valid -> out_valid and data stable, in_ready=0, no loss or duplication once released.
REQ-037 SHALL: flush asserted with 4 operations in flight and in_valid high -> next cycle out_valid never rises for them; no capture that cycle; a new operation after flush completes in 9 edges.
REQ-038 SHALL: reset_n pulsed low mid-stream -> outputs 0 asynchronously; no stale result after release.

Source files
------------

// File: rtl/pipe_divider_param.sv
// Fully pipelined unsigned restoring divider: one quotient bit per stage, full throughput.
// Define PIPE_DIV_REM_EN to expose the remainder port and carry the final remainder out.
module pipe_divider_param #(
  parameter int unsigned N_W   = 28,
  parameter int unsigned D_W   = 20,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_W-1:0]   dividend,
  input  logic [D_W-1:0]   divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_W-1:0]   quotient,
`ifdef PIPE_DIV_REM_EN
  output logic [D_W-1:0]   remainder,
`endif
  output logic             div_by_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned RW = D_W + 1;

  // Stages 0..N_W-1 keep the operands; the last stage keeps only what reaches the outputs.
  logic [N_W-1:0]   dvd_q [N_W];
  logic [D_W-1:0]   dsr_q [N_W];
  logic [RW-1:0]    rem_q [N_W];
  logic [N_W-1:0]   quo_q [N_W];
  logic [TAG_W-1:0] tag_q [N_W+1];
  logic [N_W:0]     valid_q;
  logic [N_W:0]     zero_q;
  logic [N_W-1:0]   quo_last_q;
`ifdef PIPE_DIV_REM_EN
  logic [D_W-1:0]   rem_last_q;
`endif

  // rem_d[k] / quo_d[k] are the values stage k+1 loads from stage k.
  logic [RW-1:0]  rem_d [N_W];
  logic [N_W-1:0] quo_d [N_W];

  logic stall;
  logic accept;

  assign stall    = valid_q[N_W] && !out_ready;
  assign in_ready = !stall && !flush;
  assign accept   = in_valid && in_ready;

  // A zero divisor makes every trial succeed, so the quotient fills with ones and the
  // remainder accumulates the low dividend bits without any special casing.
  always_comb begin
    logic [RW:0] sh;
    logic        ge;
    for (int k = 0; k < N_W; k++) begin
      sh       = {rem_q[k], dvd_q[k][N_W-1-k]};
      ge       = sh >= {2'b00, dsr_q[k]};
      rem_d[k] = RW'(ge ? (sh - {2'b00, dsr_q[k]}) : sh);
      quo_d[k] = quo_q[k];
      quo_d[k][N_W-1-k] = ge;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= '0;
      zero_q     <= '0;
      quo_last_q <= '0;
`ifdef PIPE_DIV_REM_EN
      rem_last_q <= '0;
`endif
      for (int k = 0; k < N_W; k++) begin
        dvd_q[k] <= '0;
        dsr_q[k] <= '0;
        rem_q[k] <= '0;
        quo_q[k] <= '0;
      end
      for (int k = 0; k <= N_W; k++) tag_q[k] <= '0;
    end else if (flush) begin
      valid_q    <= '0;
      zero_q     <= '0;
      quo_last_q <= '0;
`ifdef PIPE_DIV_REM_EN
      rem_last_q <= '0;
`endif
      for (int k = 0; k < N_W; k++) begin
        dvd_q[k] <= '0;
        dsr_q[k] <= '0;
        rem_q[k] <= '0;
        quo_q[k] <= '0;
      end
      for (int k = 0; k <= N_W; k++) tag_q[k] <= '0;
    end else if (!stall) begin
      valid_q  <= {valid_q[N_W-1:0], accept};
      zero_q   <= {zero_q[N_W-1:0], accept && (divisor == '0)};
      dvd_q[0] <= accept ? dividend : '0;
      dsr_q[0] <= accept ? divisor : '0;
      tag_q[0] <= accept ? in_tag : '0;
      rem_q[0] <= '0;
      quo_q[0] <= '0;
      for (int k = 1; k < N_W; k++) begin
        dvd_q[k] <= dvd_q[k-1];
        dsr_q[k] <= dsr_q[k-1];
        rem_q[k] <= rem_d[k-1];
        quo_q[k] <= quo_d[k-1];
      end
      for (int k = 1; k <= N_W; k++) tag_q[k] <= tag_q[k-1];
      quo_last_q <= quo_d[N_W-1];
`ifdef PIPE_DIV_REM_EN
      rem_last_q <= rem_d[N_W-1][D_W-1:0];
`endif
    end
  end

  // Bubbles carry junk quotient bits, so the outputs are gated by the valid bit.
  always_comb begin
    out_valid   = valid_q[N_W];
    quotient    = valid_q[N_W] ? quo_last_q : '0;
    div_by_zero = valid_q[N_W] && zero_q[N_W];
    out_tag     = valid_q[N_W] ? tag_q[N_W] : '0;
`ifdef PIPE_DIV_REM_EN
    remainder   = valid_q[N_W] ? rem_last_q : '0;
`endif
  end

endmodule
